rf_write_arbiter: RTL and testbench
===================================

// Module: rf_write_arbiter
// PURPOSE
//   Shares the single register-file write port (regW/regWrite/dataWrite) between
//   NREQ writeback requesters (e.g. ALU result, load result, link-address write).
//   Round-robin arbitration with per-requester valid/ready handshake.
//   Registered output stage drives the register file directly.
//   Drops writes to $zero and counts arbitration collisions.
// PARAMETERS
//   NREQ          2   number of requesters, 2..8
//   ZERO_DISCARD  1   1: accepted writes to reg 0 are consumed, rf_we stays 0
//   CNT_W         16  width of collision counter
// PORTS
//   clk        in   1          clock, all state on posedge
//   rst_n      in   1          asynchronous active-low reset
//   req_valid  in   NREQ       requester i has a pending write
//   req_addr   in   5*NREQ     dest reg of requester i, bits [5i+4:5i]
//   req_data   in   32*NREQ    write data of requester i, bits [32i+31:32i]
//   req_ready  out  NREQ       one-hot grant; transfer when valid&ready
//   hold       in   1          1: no grants this cycle (pipeline freeze)
//   rf_we      out  1          to register file regW
//   rf_waddr   out  5          to register file regWrite
//   rf_wdata   out  32         to register file dataWrite
//   grant_id   out  3          index of requester whose write is on rf_* now
//   coll_cnt   out  CNT_W      saturating count of contended grant cycles
// BEHAVIOUR
//   Reset (async, rst_n=0): rf_we=0, rf_waddr=0, rf_wdata=0, grant_id=0,
//     coll_cnt=0, rr_ptr=0. Outputs take these values immediately; no transfer
//     completes while rst_n=0. Reset mid-transfer discards the staged write.
//   Arbitration (combinational, per cycle):
//     - hold=1 or no req_valid: req_ready=0.
//     - Otherwise g = first i with req_valid[i], searching rr_ptr, rr_ptr+1, ...
//       mod NREQ; req_ready[g]=1, all others 0.
//     - req_ready never asserted to an invalid requester.
//   Staging (posedge clk):
//     - Grant g: rf_waddr<=req_addr[g], rf_wdata<=req_data[g], grant_id<=g,
//       rf_we<=1, except rf_we<=0 if ZERO_DISCARD and req_addr[g]==0.
//       rr_ptr<=(g+1) mod NREQ.
//     - No grant (hold or idle): rf_we<=0; rf_waddr/rf_wdata/grant_id/rr_ptr hold.
//   Latency: grant at edge k -> rf_we high during cycle k..k+1 -> register file
//     written at edge k+1 -> value readable on its read ports after edge k+1.
//     Consumers needing the value earlier bypass from rf_waddr/rf_wdata while rf_we=1.
//   Throughput: one write per cycle, back-to-back grants with no bubble.
//   Fairness: a requester holding valid waits at most NREQ-1 grant cycles.
//   Requester rule: while valid=1 and ready=0, addr/data must stay stable;
//     dropping valid without a transfer is allowed (no state kept).
//   Same-address requests in one cycle: serialised in grant order; later grant
//     overwrites earlier (last-granted wins).
//   coll_cnt: +1 on every grant cycle with >=2 req_valid bits set;
//     saturates at 2^CNT_W-1, no wrap.
//   hold asserted mid-stream: staged write in rf_* still completes its cycle;
//     no new grant until hold=0; rr_ptr unchanged during hold.
// TESTING
//   1 Reset: rst_n=0 with req_valid=all 1 -> req_ready=0 after async assert,
//     rf_we=0, coll_cnt=0.
//   2 Single requester: req0 writes r5=0xDEADBEEF -> req_ready=01 same cycle, rf_we=1
//     next cycle with rf_waddr=5; regfile read r5=0xDEADBEEF after following edge.
//   3 Contention: both valid 4 cycles (r1=0x11, r2=0x22, fixed) -> grants alternate
//     0,1,0,1 from rr_ptr=0; coll_cnt=4.
//   4 Zero discard: req1 writes r0=0x1234 -> req_ready[1]=1, rf_we stays 0,
//     r0 reads 0.
//   5 Hold: hold=1 for 3 cycles with req0 valid -> req_ready=0, rf_we=0;
//     hold=0 -> grant next cycle, rr_ptr unchanged.
//   6 Saturation: CNT_W=2, 5 contended grants -> coll_cnt=3.

Source files
------------

// File: rtl/rf_write_arbiter.sv
// Round-robin arbiter sharing the register-file write port among NREQ writeback
// requesters, with a registered write stage, $zero discard and a collision counter.
module rf_write_arbiter #(
  parameter int NREQ         = 2,
  parameter int ZERO_DISCARD = 1,
  parameter int CNT_W        = 16
)(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [5*NREQ-1:0]    req_addr,
  input  logic [32*NREQ-1:0]   req_data,
  output logic [NREQ-1:0]      req_ready,
  input  logic                 hold,
  output logic                 rf_we,
  output logic [4:0]           rf_waddr,
  output logic [31:0]          rf_wdata,
  output logic [2:0]           grant_id,
  output logic [CNT_W-1:0]     coll_cnt
);
  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [NREQ-1:0][4:0]  addr_a;
  logic [NREQ-1:0][31:0] data_a;
  logic [PW-1:0]         rr_ptr, off, gnt, nxt_ptr;
  logic [PW:0]           sum;
  logic [NREQ-1:0]       rot;
  logic                  gnt_vld, contended;

  assign addr_a = req_addr;
  assign data_a = req_data;

  // Rotate valids so bit 0 is the requester at rr_ptr; lowest set bit is the offset.
  assign rot = NREQ'({req_valid, req_valid} >> rr_ptr);

  always_comb begin
    off = '0;
    for (int k = NREQ-1; k >= 0; k--)
      if (rot[k]) off = PW'(k);
  end

  assign sum     = {1'b0, rr_ptr} + {1'b0, off};
  assign gnt     = (sum >= (PW+1)'(NREQ)) ? PW'(sum - (PW+1)'(NREQ)) : sum[PW-1:0];
  assign nxt_ptr = (gnt == PW'(NREQ-1)) ? '0 : gnt + PW'(1);

  // No grant may be offered while in reset, so nothing can transfer then.
  assign gnt_vld   = rst_n & ~hold & (|req_valid);
  assign req_ready = gnt_vld ? (NREQ'(1) << gnt) : '0;
  assign contended = (req_valid & (req_valid - NREQ'(1))) != '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rf_we    <= 1'b0;
      rf_waddr <= '0;
      rf_wdata <= '0;
      grant_id <= '0;
      rr_ptr   <= '0;
      coll_cnt <= '0;
    end else if (gnt_vld) begin
      rf_we    <= !((ZERO_DISCARD != 0) && (addr_a[gnt] == 5'd0));
      rf_waddr <= addr_a[gnt];
      rf_wdata <= data_a[gnt];
      grant_id <= 3'(gnt);
      rr_ptr   <= nxt_ptr;
      if (contended && (coll_cnt != '1)) coll_cnt <= coll_cnt + CNT_W'(1);
    end else begin
      rf_we <= 1'b0;
    end
  end
endmodule

// File: tb/tb_rf_write_arbiter.sv
// Randomized bench for rf_write_arbiter against a queue/array-level model of the
// arbitration rules, plus directed reset, contention, $zero, hold and saturation cases.
module tb_rf_write_arbiter;
  localparam int NREQ = 2;

  logic                   clk = 1'b0;
  logic                   rst_n = 1'b0;
  logic [NREQ-1:0]        req_valid = '0;
  logic [NREQ-1:0][4:0]   req_addr = '0;
  logic [NREQ-1:0][31:0]  req_data = '0;
  logic                   hold = 1'b0;
  logic [NREQ-1:0]        req_ready, s_ready;
  logic                   rf_we, s_we;
  logic [4:0]             rf_waddr, s_waddr;
  logic [31:0]            rf_wdata, s_wdata;
  logic [2:0]             grant_id, s_gid;
  logic [15:0]            coll_cnt;
  logic [1:0]             s_cnt;

  always #5 clk = ~clk;

  rf_write_arbiter #(.NREQ(NREQ), .ZERO_DISCARD(1), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_addr(req_addr),
    .req_data(req_data), .req_ready(req_ready), .hold(hold), .rf_we(rf_we),
    .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .grant_id(grant_id), .coll_cnt(coll_cnt));

  rf_write_arbiter #(.NREQ(NREQ), .ZERO_DISCARD(1), .CNT_W(2)) u_sat (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_addr(req_addr),
    .req_data(req_data), .req_ready(s_ready), .hold(hold), .rf_we(s_we),
    .rf_waddr(s_waddr), .rf_wdata(s_wdata), .grant_id(s_gid), .coll_cnt(s_cnt));

  // Register file as seen by the DUT's write port (no $zero guard, so stray writes show).
  logic [31:0] rf  [32] = '{default: 32'h0};
  logic [31:0] mrf [32] = '{default: 32'h0};
  always @(posedge clk) if (rf_we) rf[rf_waddr] <= rf_wdata;

  int nvec = 0, nerr = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  // Reference state
  int          m_rr = 0, m_cnt = 0, m_scnt = 0, m_gid = 0;
  logic        m_we = 0;
  logic [4:0]  m_waddr = 0;
  logic [31:0] m_wdata = 0;
  int          waitc [NREQ] = '{default: 0};

  function automatic int pick(input logic [NREQ-1:0] v, input logic h);
    int i;
    if (h) return -1;
    for (int k = 0; k < NREQ; k++) begin
      i = (m_rr + k) % NREQ;
      if (v[i]) return i;
    end
    return -1;
  endfunction

  task automatic step(input logic [NREQ-1:0] v, input logic [NREQ-1:0][4:0] a,
                      input logic [NREQ-1:0][31:0] d, input logic h, output int g);
    int   nv, cadr;
    logic commit;
    req_valid = v; req_addr = a; req_data = d; hold = h;
    #1;
    g = pick(v, h);
    chk("ready", req_ready, (g < 0) ? 0 : (1 << g));
    chk("s_ready", s_ready, (g < 0) ? 0 : (1 << g));
    // Fairness: a held valid never sits through more than NREQ-1 grants.
    for (int i = 0; i < NREQ; i++) begin
      if (v[i] && g >= 0 && g != i) begin
        waitc[i]++;
        chk("fair", (waitc[i] <= NREQ-1), 1);
      end else if (!v[i] || g == i) waitc[i] = 0;
    end
    @(posedge clk);
    commit = m_we; cadr = m_waddr;
    if (m_we) mrf[m_waddr] = m_wdata;
    if (g >= 0) begin
      m_waddr = a[g]; m_wdata = d[g]; m_gid = g; m_we = (a[g] != 0);
      m_rr = (g + 1) % NREQ;
      nv = $countones(v);
      if (nv >= 2) begin
        if (m_cnt < 65535) m_cnt++;
        if (m_scnt < 3) m_scnt++;
      end
    end else m_we = 0;
    #1;
    chk("rf_we", rf_we, m_we);
    chk("rf_waddr", rf_waddr, m_waddr);
    chk("rf_wdata", rf_wdata, m_wdata);
    chk("grant_id", grant_id, m_gid);
    chk("coll_cnt", coll_cnt, m_cnt);
    chk("sat_cnt", s_cnt, m_scnt);
    chk("s_we", s_we, m_we);
    if (commit) chk("rf_rd", rf[cadr], mrf[cadr]);
    @(negedge clk);
  endtask

  task automatic do_reset();
    req_valid = '1; hold = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("rst_ready", req_ready, 0);
    chk("rst_we", rf_we, 0);
    chk("rst_cnt", coll_cnt, 0);
    chk("rst_waddr", rf_waddr, 0);
    chk("rst_gid", grant_id, 0);
    chk("rst_wdata", s_wdata ^ rf_wdata, 0);
    m_rr = 0; m_cnt = 0; m_scnt = 0; m_gid = 0; m_we = 0; m_waddr = 0; m_wdata = 0;
    for (int i = 0; i < NREQ; i++) waitc[i] = 0;
    repeat (2) @(posedge clk);
    #1 chk("rst_hold_we", rf_we, 0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    logic [NREQ-1:0][4:0]  a;
    logic [NREQ-1:0][31:0] d;
    logic [NREQ-1:0]       v, held;
    logic                  h;
    int                    g;

    @(negedge clk);
    do_reset();

    // Single requester, then readback after the following edge
    a = '0; d = '0; a[0] = 5'd5; d[0] = 32'hDEADBEEF;
    step(2'b01, a, d, 1'b0, g);
    chk("t2_waddr", rf_waddr, 5);
    step(2'b00, a, d, 1'b0, g);
    chk("t2_r5", rf[5], 32'hDEADBEEF);

    // Contention from rr_ptr=0
    do_reset();
    a[0] = 5'd1; a[1] = 5'd2; d[0] = 32'h11; d[1] = 32'h22;
    for (int i = 0; i < 4; i++) begin
      step(2'b11, a, d, 1'b0, g);
      chk("t3_gid", grant_id, i % 2);
    end
    chk("t3_coll", coll_cnt, 4);

    // $zero discard
    a[1] = 5'd0; d[1] = 32'h1234;
    step(2'b10, a, d, 1'b0, g);
    chk("t4_we", rf_we, 0);
    step(2'b00, a, d, 1'b0, g);
    chk("t4_r0", rf[0], 0);

    // Hold freezes grants and rr_ptr
    a[0] = 5'd9; d[0] = 32'hCAFE0009;
    for (int i = 0; i < 3; i++) step(2'b01, a, d, 1'b1, g);
    chk("t5_we", rf_we, 0);
    step(2'b01, a, d, 1'b0, g);
    chk("t5_gid", grant_id, 0);

    // Saturation of the 2-bit counter
    do_reset();
    a[0] = 5'd3; a[1] = 5'd4;
    for (int i = 0; i < 5; i++) step(2'b11, a, d, 1'b0, g);
    chk("t6_sat", s_cnt, 3);

    // Randomized traffic honouring the stable-while-waiting rule
    held = '0; v = '0;
    for (int n = 0; n < 400; n++) begin
      if (n == 200) begin do_reset(); held = '0; v = '0; end
      for (int i = 0; i < NREQ; i++) begin
        if (!(held[i] && $urandom_range(7) != 0)) begin
          v[i] = ($urandom_range(3) != 0);
          a[i] = ($urandom_range(3) == 0) ? 5'd0 : 5'($urandom_range(31));
          d[i] = $urandom;
        end
      end
      if ($urandom_range(5) == 0) a[1] = a[0];
      h = ($urandom_range(5) == 0);
      step(v, a, d, h, g);
      held = v & ~((g >= 0) ? NREQ'(1) << g : NREQ'(0));
    end
    step(2'b00, a, d, 1'b0, g);
    for (int r = 1; r < 32; r++) chk("final_rf", rf[r], mrf[r]);
    chk("final_r0", rf[0], 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
